// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor instruction sequencer:
// opcode field values, the default halt word and the FSM state encoding.
package proc_ctrl_pkg;

  localparam logic [2:0]  OP_MV  = 3'd0;
  localparam logic [2:0]  OP_MVI = 3'd1;
  localparam logic [2:0]  OP_ADD = 3'd2;
  localparam logic [2:0]  OP_SUB = 3'd3;

  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_PAUSED = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } seq_state_e;

endpackage

// File: rtl/wdog_counter.sv
// Watchdog for a Done-style handshake. Cleared when a request is issued,
// counts each enabled waiting cycle, and flags the cycle whose increment
// would reach TIMEOUT-1 so the owner can give up on that same edge.
module wdog_counter #(
  parameter int TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Count waiting cycles; hold at TIMEOUT-1 so the count never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT - 1))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 2));

endmodule

// File: rtl/proc_seq_ctrl.sv
// Instruction sequencer between a synchronous instruction ROM and proc.
// Fetches one word per instruction, issues it with a single Run pulse,
// supplies the mvi immediate during WAIT, and waits for Done. Adds halt
// detection, a Done watchdog, pause and a saturating retired counter.
module proc_seq_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int              AW        = 5,
  parameter int              DW        = 16,
  parameter int              TIMEOUT   = 8,
  parameter logic [DW-1:0]   HALT_WORD = DW'(HALT_WORD_DEF)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Pause,
  input  logic [AW-1:0] StartAddr,
  output logic [AW-1:0] MemAddr,
  input  logic [DW-1:0] MemData,
  output logic [DW-1:0] DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [AW-1:0] PC,
  output logic [15:0]   InstrCount
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q;
  logic          mvi_q, mvi_d;
  logic          halted_q, halted_d;
  logic          error_q, error_d;
  logic [15:0]   icnt_q, icnt_d;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] din;
  logic          run;
  logic          wd_clr, wd_en, wd_tc;
  logic          is_halt, is_mvi;

  assign is_halt = (MemData == HALT_WORD);
  assign is_mvi  = (MemData[8:6] == OP_MVI);

  wdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i (Clock),
    .rst_i (Reset),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  // Next-state, PC update and the combinational ROM address / DIN / Run outputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mvi_d    = mvi_q;
    halted_d = halted_q;
    error_d  = error_q;
    icnt_d   = icnt_q;
    mem_addr = addr_q;
    din      = '0;
    run      = 1'b0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT, S_ERR, S_PAUSED: begin
        if (Start) begin
          pc_d     = StartAddr;
          halted_d = 1'b0;
          error_d  = 1'b0;
          state_d  = S_FETCH;
        end else if ((state_q == S_PAUSED) && !Pause) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_addr = pc_q;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (is_halt) begin
          // PC stays on the halt word so a debugger can see where it stopped.
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          din      = MemData;
          run      = 1'b1;
          mem_addr = pc_q + AW'(1);
          pc_d     = pc_q + (is_mvi ? AW'(2) : AW'(1));
          mvi_d    = is_mvi;
          wd_clr   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Address is held at PC+1, so the immediate stays on MemData.
        din = mvi_q ? MemData : '0;
        if (Done) begin
          if (icnt_q != 16'hFFFF) icnt_d = icnt_q + 16'd1;
          state_d = Pause ? S_PAUSED : S_FETCH;
        end else begin
          wd_en = 1'b1;
          if (wd_tc) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural state registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      mvi_q    <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      icnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= mem_addr;
      mvi_q    <= mvi_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      icnt_q   <= icnt_d;
    end
  end

  assign MemAddr    = mem_addr;
  assign DIN        = din;
  assign Run        = run;
  assign Busy       = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_WAIT);
  assign Halted     = halted_q;
  assign Error      = error_q;
  assign PC         = pc_q;
  assign InstrCount = icnt_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Directed bench for proc_seq_ctrl with a synchronous ROM model and a
// hand-driven Done line; expected values are written out per cycle.
module tb_proc_seq_ctrl;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int TIMEOUT = 8;

  logic          Clock = 1'b0;
  logic          Reset, Start, Pause, Done;
  logic [AW-1:0] StartAddr;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemData;
  logic [DW-1:0] DIN;
  logic          Run, Busy, Halted, Error;
  logic [AW-1:0] PC;
  logic [15:0]   InstrCount;

  logic [DW-1:0] rom [32];

  int n_checks = 0;
  int n_fail   = 0;

  proc_seq_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Pause      (Pause),
    .StartAddr  (StartAddr),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .DIN        (DIN),
    .Run        (Run),
    .Done       (Done),
    .Busy       (Busy),
    .Halted     (Halted),
    .Error      (Error),
    .PC         (PC),
    .InstrCount (InstrCount)
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM: data for the address seen at an edge appears after it.
  always @(posedge Clock) MemData <= rom[MemAddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h0001;  // mv R0,R1
    rom[1]  = 16'h0050;  // mvi R2,#imm
    rom[2]  = 16'h00A5;  // immediate
    rom[3]  = 16'hFFFF;  // halt
    rom[31] = 16'h0040;  // mvi at the top of the address space

    Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Done = 1'b0; StartAddr = '0;
    tick(); tick();
    Reset = 1'b0;
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_pc", PC, 0);
    check_eq("rst_run", Run, 0);
    check_eq("rst_din", DIN, 0);
    check_eq("rst_addr", MemAddr, 0);
    check_eq("rst_halt", Halted, 0);
    check_eq("rst_err", Error, 0);
    check_eq("rst_icnt", InstrCount, 0);

    // mv at address 0, Done three cycles after Run
    StartAddr = 5'd0; Start = 1'b1;
    tick(); Start = 1'b0;                         // FETCH
    check_eq("f0_busy", Busy, 1);
    check_eq("f0_addr", MemAddr, 0);
    check_eq("f0_run", Run, 0);
    tick();                                       // DECODE, cycle 2
    check_eq("d0_run", Run, 1);
    check_eq("d0_din", DIN, 16'h0001);
    check_eq("d0_addr", MemAddr, 1);
    tick();                                       // WAIT
    check_eq("w0_run", Run, 0);
    check_eq("w0_din", DIN, 0);
    check_eq("w0_pc", PC, 1);
    tick(); tick();
    Done = 1'b1;
    check_eq("w0_icnt_pre", InstrCount, 0);
    tick(); Done = 1'b0;                          // FETCH at 1
    check_eq("f1_icnt", InstrCount, 1);
    check_eq("f1_addr", MemAddr, 1);
    check_eq("f1_busy", Busy, 1);

    // mvi with immediate
    tick();
    check_eq("d1_run", Run, 1);
    check_eq("d1_din", DIN, 16'h0050);
    check_eq("d1_addr", MemAddr, 2);
    tick();
    check_eq("w1_din", DIN, 16'h00A5);
    check_eq("w1_pc", PC, 3);
    check_eq("w1_run", Run, 0);
    tick();
    check_eq("w1_din_hold", DIN, 16'h00A5);
    Done = 1'b1;
    tick(); Done = 1'b0;
    check_eq("f3_icnt", InstrCount, 2);
    check_eq("f3_addr", MemAddr, 3);

    // halt word
    tick();
    check_eq("d3_run", Run, 0);
    tick();
    check_eq("h_halted", Halted, 1);
    check_eq("h_busy", Busy, 0);
    check_eq("h_pc", PC, 3);
    check_eq("h_din", DIN, 0);
    tick();
    check_eq("h_run", Run, 0);
    check_eq("h_sticky", Halted, 1);

    // restart from halt, then let the watchdog expire
    StartAddr = 5'd0; Start = 1'b1;
    tick(); Start = 1'b0;
    check_eq("rs_halted", Halted, 0);
    check_eq("rs_busy", Busy, 1);
    check_eq("rs_pc", PC, 0);
    tick();
    check_eq("wd_run", Run, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check_eq("wd_err_early", Error, 0);
    check_eq("wd_busy_early", Busy, 1);
    tick();
    check_eq("wd_err", Error, 1);
    check_eq("wd_busy", Busy, 0);
    check_eq("wd_run_off", Run, 0);
    Done = 1'b1;
    tick(); Done = 1'b0;
    check_eq("err_done_ign", InstrCount, 2);
    check_eq("err_sticky", Error, 1);
    StartAddr = 5'd0; Start = 1'b1;
    tick(); Start = 1'b0;
    check_eq("err_clr", Error, 0);

    // pause after retire
    tick();
    check_eq("p_run", Run, 1);
    tick();
    Pause = 1'b1; Done = 1'b1;
    tick(); Done = 1'b0;
    check_eq("p_busy", Busy, 0);
    check_eq("p_icnt", InstrCount, 3);
    check_eq("p_pc", PC, 1);
    tick();
    check_eq("p_run_off", Run, 0);
    check_eq("p_hold", Busy, 0);
    Pause = 1'b0;
    tick();
    check_eq("p_res_busy", Busy, 1);
    check_eq("p_res_addr", MemAddr, 1);
    tick();
    check_eq("p_res_din", DIN, 16'h0050);
    StartAddr = 5'd10; Start = 1'b1;              // ignored while busy
    tick(); Start = 1'b0;
    check_eq("busy_start_ign", PC, 3);

    // reset mid-WAIT
    Reset = 1'b1;
    tick(); Reset = 1'b0;
    check_eq("mr_pc", PC, 0);
    check_eq("mr_busy", Busy, 0);
    check_eq("mr_icnt", InstrCount, 0);
    check_eq("mr_din", DIN, 0);
    check_eq("mr_addr", MemAddr, 0);

    // mvi at the last address wraps to the immediate at 0
    StartAddr = 5'd31; Start = 1'b1;
    tick(); Start = 1'b0;
    check_eq("wr_faddr", MemAddr, 31);
    tick();
    check_eq("wr_run", Run, 1);
    check_eq("wr_din", DIN, 16'h0040);
    check_eq("wr_addr", MemAddr, 0);
    tick();
    check_eq("wr_imm", DIN, 16'h0001);
    check_eq("wr_pc", PC, 1);
    Done = 1'b1;
    tick(); Done = 1'b0;
    check_eq("wr_next", MemAddr, 1);
    check_eq("wr_icnt", InstrCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
